// File: rtl/m_seq_chk_if.sv
// Serial PRBS link bundle: stream and clear from the line side, lock/error status back.
// master drives the stream; slave is the checker.
interface m_seq_chk_if #(
  parameter int CNT_W = 16
);
  logic             din;
  logic             din_vld;
  logic             clr_cnt;
  logic             lock;
  logic             err;
  logic             sync_lost;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output din, din_vld, clr_cnt,
    input  lock, err, sync_lost, err_cnt
  );

  modport slave (
    input  din, din_vld, clr_cnt,
    output lock, err, sync_lost, err_cnt
  );
endinterface

// File: rtl/m_seq_chk.sv
// Receive-side checker for the 4-bit m-sequence y(n+4)=y(n+3)^y(n): hunts, verifies, then flywheels.
// Status outputs are registered on the edge that samples the triggering bit; din_vld=0 freezes state.
module m_seq_chk #(
  parameter int LOCK_CNT = 8,
  parameter int WIN      = 32,
  parameter int LOSS_THR = 4,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         res,
  m_seq_chk_if.slave   bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int EW = $clog2(LOSS_THR + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state;
  logic [3:0]       hist;
  logic [1:0]       fill;
  logic [MW-1:0]    mcnt;
  logic [WW-1:0]    win_cnt;
  logic [EW-1:0]    win_err;
  logic             lock_q;
  logic             err_q;
  logic             sync_lost_q;
  logic [CNT_W-1:0] cnt_q;

  logic             pred;
  logic             mis;
  logic [EW-1:0]    win_err_n;

  assign pred      = hist[3] ^ hist[0];
  assign mis       = bus.din_vld && (state == LOCKED) && (bus.din != pred);
  assign win_err_n = win_err + EW'(mis);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= HUNT;
      hist        <= 4'd0;
      fill        <= 2'd0;
      mcnt        <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
      sync_lost_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      err_q       <= 1'b0;
      sync_lost_q <= 1'b0;

      // Clear wins over increment, but the same cycle's error still lands.
      if (bus.clr_cnt)
        cnt_q <= CNT_W'(mis);
      else if (mis && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;

      if (bus.din_vld) begin
        case (state)
          HUNT: begin
            hist <= {bus.din, hist[3:1]};
            if (fill == 2'd3) begin
              fill  <= 2'd0;
              mcnt  <= '0;
              state <= VERIFY;
            end else begin
              fill <= fill + 2'd1;
            end
          end

          VERIFY: begin
            hist <= {bus.din, hist[3:1]};
            // All-zero history is the degenerate fixed point; it must never count toward lock.
            if ((bus.din == pred) && (hist != 4'd0)) begin
              if (mcnt == MW'(LOCK_CNT - 1)) begin
                mcnt    <= '0;
                win_cnt <= '0;
                win_err <= '0;
                lock_q  <= 1'b1;
                state   <= LOCKED;
              end else begin
                mcnt <= mcnt + 1'b1;
              end
            end else begin
              mcnt <= '0;
            end
          end

          LOCKED: begin
            // Flywheel on the prediction so a line error does not corrupt the history.
            hist  <= {pred, hist[3:1]};
            err_q <= mis;
            if (win_err_n == EW'(LOSS_THR)) begin
              state       <= HUNT;
              lock_q      <= 1'b0;
              sync_lost_q <= 1'b1;
              fill        <= 2'd0;
              win_cnt     <= '0;
              win_err     <= '0;
            end else if (win_cnt == WW'(WIN - 1)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              win_err <= win_err_n;
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.lock      = lock_q;
  assign bus.err       = err_q;
  assign bus.sync_lost = sync_lost_q;
  assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_m_seq_chk.sv
// Bench for m_seq_chk with a 3-bit error counter so saturation is reachable.
// Expected status is queued as each bit is driven and popped one edge later.
module tb_m_seq_chk;
  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  m_seq_chk_if #(.CNT_W(3)) bus ();

  m_seq_chk #(
    .LOCK_CNT(8),
    .WIN(32),
    .LOSS_THR(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  typedef struct packed {
    logic       lock;
    logic       err;
    logic       sl;
    logic [2:0] cnt;
  } exp_t;

  typedef struct {
    logic din;
    logic vld;
    logic clr;
    exp_t e;
  } vec_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  bit         seq[15] = '{1,1,1,1,0,1,0,1,1,0,0,1,0,0,0};
  int         ph = 0;
  int         lk = 0;
  logic [2:0] cnt_exp = 3'd0;
  vec_t       tab[30];

  function automatic exp_t mk(logic l, logic e, logic s, logic [2:0] c);
    exp_t r;
    r.lock = l;
    r.err  = e;
    r.sl   = s;
    r.cnt  = c;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic c, input exp_t e);
    exp_t x;
    bus.din     = d;
    bus.din_vld = v;
    bus.clr_cnt = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("lock", int'(bus.lock), int'(x.lock));
    chk("err", int'(bus.err), int'(x.err));
    chk("sync_lost", int'(bus.sync_lost), int'(x.sl));
    chk("err_cnt", int'(bus.err_cnt), int'(x.cnt));
  endtask

  // One bit while locked; inv flips the line bit, sl marks the bit expected to drop lock.
  task automatic lk_bit(input logic inv, input logic sl, input logic clr);
    if (clr) cnt_exp = 3'd0;
    if (inv && cnt_exp != 3'd7) cnt_exp = cnt_exp + 3'd1;
    step(seq[ph] ^ inv, 1'b1, clr, mk(!sl, inv, sl, cnt_exp));
    ph = (ph + 1) % 15;
    if (!sl) lk++;
  endtask

  task automatic relock();
    for (int i = 1; i <= 12; i++) begin
      step(seq[ph], 1'b1, 1'b0, mk(i == 12, 1'b0, 1'b0, cnt_exp));
      ph = (ph + 1) % 15;
    end
    lk = 0;
  endtask

  // Reset must act without a clock edge: check 2ns after assertion, mid-cycle.
  task automatic do_reset();
    bus.din     = 1'b0;
    bus.din_vld = 1'b0;
    bus.clr_cnt = 1'b0;
    res = 1'b1;
    #2;
    chk("rst_lock", int'(bus.lock), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_sync_lost", int'(bus.sync_lost), 0);
    chk("rst_err_cnt", int'(bus.err_cnt), 0);
    @(posedge clk);
    #1;
    res = 1'b0;
    cnt_exp = 3'd0;
    ph = 0;
    lk = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;

    do_reset();

    // Clean stream from the all-ones seed: lock rises on the 12th bit.
    for (int i = 0; i < 30; i++) begin
      tab[i].din = seq[i % 15];
      tab[i].vld = 1'b1;
      tab[i].clr = 1'b0;
      tab[i].e   = mk(i >= 11, 1'b0, 1'b0, 3'd0);
    end
    for (int i = 0; i < 30; i++)
      step(tab[i].din, tab[i].vld, tab[i].clr, tab[i].e);
    ph = 0;
    lk = 30 - 12;

    // Single inverted bit: one err pulse, no follow-on errors.
    repeat (5) lk_bit(1'b0, 1'b0, 1'b0);
    lk_bit(1'b1, 1'b0, 1'b0);
    repeat (50) lk_bit(1'b0, 1'b0, 1'b0);

    // Four errors within one window: sync lost on the 4th, then relock.
    while (lk % 32 != 0) lk_bit(1'b0, 1'b0, 1'b0);
    for (int o = 0; o <= 28; o++)
      lk_bit(o == 3 || o == 10 || o == 20 || o == 28, o == 28, 1'b0);
    relock();

    // Errors straddling a window wrap do not accumulate; counter saturates at 7.
    for (int o = 0; o < 32; o++) lk_bit(o >= 29, 1'b0, 1'b0);
    lk_bit(1'b1, 1'b0, 1'b0);
    for (int o = 1; o <= 28; o++) lk_bit(1'b0, 1'b0, 1'b0);
    // The wrap bit's own error is the 4th in this window.
    for (int o = 29; o <= 31; o++) lk_bit(1'b1, o == 31, 1'b0);
    relock();

    // Clear with a simultaneous error leaves 1; clear alone leaves 0.
    lk_bit(1'b1, 1'b0, 1'b1);
    lk_bit(1'b0, 1'b0, 1'b1);
    repeat (3) lk_bit(1'b0, 1'b0, 1'b0);

    // Asynchronous reset while locked.
    do_reset();

    // Stuck-at-0 never locks; the clean stream that follows locks on its 9th bit
    // because the trailing zeros already match the sequence's 000 run.
    repeat (100) step(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 3'd0));
    for (int i = 1; i <= 20; i++) begin
      step(seq[ph], 1'b1, 1'b0, mk(i >= 9, 1'b0, 1'b0, 3'd0));
      ph = (ph + 1) % 15;
    end

    // din_vld toggling with garbage on invalid cycles.
    do_reset();
    nv = 0;
    while (nv < 24) begin
      nv++;
      step(seq[ph], 1'b1, 1'b0, mk(nv >= 12, 1'b0, 1'b0, 3'd0));
      ph = (ph + 1) % 15;
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, mk(nv >= 12, 1'b0, 1'b0, 3'd0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
